iter_rect: RTL and testbench

ITER_RECT -- requirements
Module: iter_rect

---
 rtl/iter_rect_if.sv | 33 +++
 rtl/iter_rect.sv | 126 ++++++++++++
 tb/tb_iter_rect.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/iter_rect_if.sv
// Rectangle iterator bus: request fields, point stream and status lines.
// Latency: n/a (signal bundle only).
// Backpressure: oe from the consumer gates every step of the iterator.
//
// Ports (per modport):
//   slave  (iterator): in start, oe, x0, y0, w, h, outline; out x, y, drawing, busy, done
//   master (client):   the mirror image of slave
interface iter_rect_if #(
    parameter int CORDW = 10
);
    logic             start;
    logic             oe;
    logic [CORDW-1:0] x0;
    logic [CORDW-1:0] y0;
    logic [CORDW-1:0] w;
    logic [CORDW-1:0] h;
    logic             outline;
    logic [CORDW-1:0] x;
    logic [CORDW-1:0] y;
    logic             drawing;
    logic             busy;
    logic             done;

    modport master (
        output start, oe, x0, y0, w, h, outline,
        input  x, y, drawing, busy, done
    );

    modport slave (
        input  start, oe, x0, y0, w, h, outline,
        output x, y, drawing, busy, done
    );
endinterface

// File: rtl/iter_rect.sv
// Walks the points of a filled or outlined rectangle, one point per enabled cycle.
// Latency: first point one cycle after start is taken; done pulses one cycle after the last point.
// Backpressure: oe low freezes x, y and state; each point consumes exactly one oe-high cycle.
//
// Ports: clk, rst (synchronous, active high); bus (iter_rect_if.slave) carries
//   start/oe/x0/y0/w/h/outline in and x/y/drawing/busy/done out.
// Optional build macro: ITER_RECT_CLIP_EN -- suppresses drawing for points at or
//   beyond CLIP_W/CLIP_H without changing the iteration timing.
module iter_rect #(
    parameter int          CORDW  = 10,
    parameter int unsigned CLIP_W = 640,
    parameter int unsigned CLIP_H = 480
) (
    input  logic        clk,
    input  logic        rst,
    iter_rect_if.slave  bus
);

    // IDLE encoded as zero so an uninitialised two-state register starts idle.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        DRAW = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t state, state_n;

    logic [CORDW-1:0] x_q, y_q, x_n, y_n;
    logic [CORDW-1:0] xs_q, ys_q;   // latched top-left corner
    logic [CORDW-1:0] x1_q, y1_q;   // latched, saturated bottom-right corner
    logic             outl_q;
    logic             load;

    // End coordinates need one extra bit so x0+w-1 can be seen to overflow.
    logic [CORDW:0]   xe_sum, ye_sum;
    logic [CORDW-1:0] x1_n, y1_n;

    assign xe_sum = {1'b0, bus.x0} + {1'b0, bus.w} - (CORDW+1)'(1);
    assign ye_sum = {1'b0, bus.y0} + {1'b0, bus.h} - (CORDW+1)'(1);
    assign x1_n   = xe_sum[CORDW] ? '1 : xe_sum[CORDW-1:0];
    assign y1_n   = ye_sum[CORDW] ? '1 : ye_sum[CORDW-1:0];

    logic last_col, last_row, skip_mid;
    assign last_col = (x_q == x1_q);
    assign last_row = (y_q == y1_q);
    // Outline interior rows jump from the left edge straight to the right edge.
    // last_col being false here already implies the row is wider than one point.
    assign skip_mid = outl_q && (y_q != ys_q) && !last_row && (x_q == xs_q);

    logic point_visible;
`ifdef ITER_RECT_CLIP_EN
    assign point_visible = (32'(x_q) < CLIP_W) && (32'(y_q) < CLIP_H);
`else
    assign point_visible = 1'b1;
    logic unused_clip;
    assign unused_clip = CLIP_W[0] ^ CLIP_H[0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Datapath needs no reset: it is only observed while in DRAW, which is
    // always entered through a load.
    always_ff @(posedge clk) begin
        x_q <= x_n;
        y_q <= y_n;
        if (load) begin
            xs_q   <= bus.x0;
            ys_q   <= bus.y0;
            x1_q   <= x1_n;
            y1_q   <= y1_n;
            outl_q <= bus.outline;
        end
    end

    always_comb begin
        state_n = state;
        x_n     = x_q;
        y_n     = y_q;
        load    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    x_n     = bus.x0;
                    y_n     = bus.y0;
                    state_n = (bus.w == '0 || bus.h == '0) ? DONE : DRAW;
                end
            end
            DRAW: begin
                if (bus.oe) begin
                    if (last_col) begin
                        if (last_row) begin
                            state_n = DONE;
                        end else begin
                            x_n = xs_q;
                            y_n = y_q + CORDW'(1);
                        end
                    end else if (skip_mid) begin
                        x_n = x1_q;
                    end else begin
                        x_n = x_q + CORDW'(1);
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.x       = x_q;
    assign bus.y       = y_q;
    assign bus.busy    = (state == DRAW);
    assign bus.done    = (state == DONE);
    assign bus.drawing = (state == DRAW) && bus.oe && point_visible;

endmodule

// File: tb/tb_iter_rect.sv
// Directed bench for iter_rect: table of rectangles with expected point
// streams and timing, plus hand-written start/reset corner sequences.
module tb_iter_rect;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    iter_rect_if #(.CORDW(10)) bus();

    iter_rect #(.CORDW(10), .CLIP_W(640), .CLIP_H(480)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
        end
    endtask

    typedef struct {
        string      name;
        logic [9:0] x0, y0, w, h;
        logic       outl;
        logic       stall;
        int         npts;
        int         done_k;   // cycles after the start edge until done is seen
        int         busy_k;
        int         base;
    } vec_t;

    vec_t       vt[10];
    int         nv = 0;
    logic [9:0] ex_x[40];
    logic [9:0] ex_y[40];
    int         np = 0;

    task automatic add_vec(input string nm, input int x0, input int y0, input int w, input int h,
                           input bit outl, input bit stall, input int npts, input int done_k, input int busy_k);
        vt[nv].name   = nm;
        vt[nv].x0     = 10'(x0);
        vt[nv].y0     = 10'(y0);
        vt[nv].w      = 10'(w);
        vt[nv].h      = 10'(h);
        vt[nv].outl   = outl;
        vt[nv].stall  = stall;
        vt[nv].npts   = npts;
        vt[nv].done_k = done_k;
        vt[nv].busy_k = busy_k;
        vt[nv].base   = np;
        nv++;
    endtask

    task automatic ap(input int xx, input int yy);
        ex_x[np] = 10'(xx);
        ex_y[np] = 10'(yy);
        np++;
    endtask

    task automatic run_vec(input vec_t v);
        int idx, busy_n, done_k, overlap;
        idx = 0; busy_n = 0; done_k = -1; overlap = 0;
        @(negedge clk);
        bus.x0 = v.x0; bus.y0 = v.y0; bus.w = v.w; bus.h = v.h;
        bus.outline = v.outl; bus.oe = 1'b1; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int k = 1; k <= 200 && done_k < 0; k++) begin
            bus.oe = v.stall ? (k % 2 == 0) : 1'b1;
            @(negedge clk);
            if (bus.drawing) begin
                if (idx < v.npts) begin
                    check({v.name, "_pt"}, {12'd0, bus.x, bus.y},
                          {12'd0, ex_x[v.base+idx], ex_y[v.base+idx]});
                end else begin
                    check({v.name, "_extra_pt"}, 1, 0);
                end
                idx++;
            end
            if (bus.busy) busy_n++;
            if (bus.busy && bus.done) overlap++;
            if (bus.done) done_k = k;
            @(posedge clk); #1;
        end
        check({v.name, "_npts"},    idx,     v.npts);
        check({v.name, "_done_k"},  done_k,  v.done_k);
        check({v.name, "_busy_n"},  busy_n,  v.busy_k);
        check({v.name, "_overlap"}, overlap, 0);
        bus.oe = 1'b1;
        @(negedge clk);
        check({v.name, "_post_idle"}, {bus.busy, bus.done}, 2'b00);
    endtask

    initial begin
        // name, x0, y0, w, h, outline, stall, npts, done_k, busy_k
        add_vec("fill3x2", 2, 3, 3, 2, 0, 0, 6, 7, 6);
        ap(2,3); ap(3,3); ap(4,3); ap(2,4); ap(3,4); ap(4,4);
        add_vec("outl4x3", 0, 0, 4, 3, 1, 0, 10, 11, 10);
        ap(0,0); ap(1,0); ap(2,0); ap(3,0); ap(0,1); ap(3,1);
        ap(0,2); ap(1,2); ap(2,2); ap(3,2);
        add_vec("w0", 3, 3, 0, 5, 0, 0, 0, 1, 0);
        add_vec("xsat", 1022, 5, 5, 1, 0, 0, 2, 3, 2);
        ap(1022,5); ap(1023,5);
        add_vec("outl_w1", 7, 8, 1, 3, 1, 0, 3, 4, 3);
        ap(7,8); ap(7,9); ap(7,10);
        add_vec("h0", 1, 1, 3, 0, 0, 0, 0, 1, 0);
        add_vec("ysat", 4, 1022, 2, 4, 0, 0, 4, 5, 4);
        ap(4,1022); ap(5,1022); ap(4,1023); ap(5,1023);
        add_vec("stall2x2", 10, 20, 2, 2, 0, 1, 4, 9, 8);
        ap(10,20); ap(11,20); ap(10,21); ap(11,21);

        bus.start = 1'b0; bus.oe = 1'b1; bus.outline = 1'b0;
        bus.x0 = '0; bus.y0 = '0; bus.w = '0; bus.h = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_flags", {bus.drawing, bus.busy, bus.done}, 3'b000);
        rst = 1'b0;

        for (int i = 0; i < nv; i++) run_vec(vt[i]);

        // start held high: ignored while in DRAW and DONE, inputs changed mid-run ignored,
        // then taken again in the following IDLE cycle.
        @(negedge clk);
        bus.x0 = 10'd0; bus.y0 = 10'd0; bus.w = 10'd2; bus.h = 10'd1;
        bus.outline = 1'b0; bus.oe = 1'b1; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.x0 = 10'd5; bus.y0 = 10'd5; bus.w = 10'd3; bus.h = 10'd1;
        @(negedge clk);
        check("hold_k1_flags", {bus.drawing, bus.busy, bus.done}, 3'b110);
        check("hold_k1_pt", {bus.x, bus.y}, {10'd0, 10'd0});
        @(negedge clk);
        check("hold_k2_flags", {bus.drawing, bus.busy, bus.done}, 3'b110);
        check("hold_k2_pt", {bus.x, bus.y}, {10'd1, 10'd0});
        @(negedge clk);
        check("hold_k3_done", {bus.drawing, bus.busy, bus.done}, 3'b001);
        @(negedge clk);
        check("hold_k4_idle", {bus.drawing, bus.busy, bus.done}, 3'b000);
        @(negedge clk);
        check("hold_k5_restart", {bus.drawing, bus.busy, bus.done}, 3'b110);
        check("hold_k5_pt", {bus.x, bus.y}, {10'd5, 10'd5});
        bus.start = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // reset in the middle of a 4x4 fill after three points, then a clean restart.
        @(negedge clk);
        bus.x0 = 10'd1; bus.y0 = 10'd1; bus.w = 10'd4; bus.h = 10'd4;
        bus.outline = 1'b0; bus.oe = 1'b1; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_pt3", {bus.drawing, bus.x, bus.y}, {1'b1, 10'd3, 10'd1});
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_flags", {bus.drawing, bus.busy, bus.done}, 3'b000);
        @(negedge clk);
        check("mid_no_pulse", {bus.busy, bus.done}, 2'b00);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        check("mid_restart_pt", {bus.drawing, bus.busy, bus.x, bus.y}, {2'b11, 10'd1, 10'd1});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
